// File: rtl/sr_arb_pkg.sv
// ---------------------------------------------------------------------------
// sr_arb_pkg
// Shared types and helpers for the SR bank arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, LOCKED)
//   CMD_*       : per-bit {s,r} command encodings applied to the SR bank
//   MAX_REQ     : largest supported requester count
//   onehot()    : index -> one-hot vector of MAX_REQ bits
// ---------------------------------------------------------------------------
package sr_arb_pkg;

   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   // {s, r} pairs
   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_BAD  = 2'b11;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
      logic [MAX_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sr_rr_pick.sv
// ---------------------------------------------------------------------------
// sr_rr_pick
// Combinational round-robin picker: returns the first set bit of 'eligible'
// scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
// Ports:
//   eligible [NREQ-1:0]  candidate mask
//   ptr      [PTR_W-1:0] scan start index (always < NREQ)
//   winner   [PTR_W-1:0] selected index (0 when valid is low)
//   valid                at least one eligible bit was found
// ---------------------------------------------------------------------------
module sr_rr_pick #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  eligible,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] winner,
   output logic             valid
);

   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!valid && eligible[idx]) begin
            valid  = 1'b1;
            winner = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/sr_bank_arbiter.sv
// ---------------------------------------------------------------------------
// sr_bank_arbiter
// Round-robin arbiter sharing one WIDTH-bit SR flip-flop bank among NREQ
// requesters. One command is applied per cycle; s=r=1 on a bit holds the bit
// and raises err for one cycle.
// Optional feature macro: SR_ARB_LOCK_EN (enables lock input / LOCKED state).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req   [NREQ-1:0]  per-requester command valid (level)
//   s_bus, r_bus      packed set/reset vectors, requester i at [i*WIDTH +: WIDTH]
//   lock  [NREQ-1:0]  hold-ownership request (only with SR_ARB_LOCK_EN)
//   gnt   [NREQ-1:0]  registered one-hot: whose command was applied last edge
//   q     [WIDTH-1:0] SR bank contents
//   err               registered, one cycle after an applied s=r=1 bit
//   busy              arbiter is in GRANT or LOCKED
// ---------------------------------------------------------------------------
module sr_bank_arbiter
   import sr_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] s_bus,
   input  logic [NREQ*WIDTH-1:0] r_bus,
   input  logic [NREQ-1:0]       lock,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic                  err,
   output logic                  busy
);

   localparam int PTR_W = $clog2(NREQ);

   arb_state_t         state_reg, state_next;
   logic [PTR_W-1:0]   ptr_reg, ptr_next;
   logic [NREQ-1:0]    gnt_reg, gnt_next;
   logic [WIDTH-1:0]   q_reg, q_next;
   logic               err_reg, err_next;

   logic [WIDTH-1:0]   s_arr [NREQ];
   logic [WIDTH-1:0]   r_arr [NREQ];
   logic [NREQ-1:0]    eligible;
   logic [PTR_W-1:0]   pick_idx, win_idx;
   logic               pick_valid, win_valid;
   logic [MAX_REQ-1:0] win_oh;
   logic [WIDTH-1:0]   s_w, r_w;

`ifdef SR_ARB_LOCK_EN
   logic [PTR_W-1:0]   owner_reg, owner_next;
`else
   logic               unused_lock;
   assign unused_lock = ^lock;
`endif

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign s_arr[gi] = s_bus[gi*WIDTH +: WIDTH];
         assign r_arr[gi] = r_bus[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // A requester granted last edge is masked so it cannot replay the same
   // command; the lock owner bypasses this by winning unconditionally below.
   assign eligible = req & ~gnt_reg;

   sr_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .eligible (eligible),
      .ptr      (ptr_reg),
      .winner   (pick_idx),
      .valid    (pick_valid)
   );

   always_comb begin
      win_idx    = pick_idx;
      win_valid  = pick_valid;
      state_next = IDLE;
      ptr_next   = ptr_reg;
      gnt_next   = '0;
      q_next     = q_reg;
      err_next   = 1'b0;
      win_oh     = '0;
      s_w        = '0;
      r_w        = '0;
`ifdef SR_ARB_LOCK_EN
      owner_next = owner_reg;
      if (state_reg == LOCKED && req[owner_reg] && lock[owner_reg]) begin
         win_idx   = owner_reg;
         win_valid = 1'b1;
      end
`endif

      if (win_valid) begin
         state_next = GRANT;
`ifdef SR_ARB_LOCK_EN
         // A locking winner enters (or stays in) LOCKED from any state.
         if (lock[win_idx]) begin
            state_next = LOCKED;
            owner_next = win_idx;
         end
`endif
         ptr_next = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + PTR_W'(1);
         win_oh   = onehot(3'(win_idx));
         gnt_next = win_oh[NREQ-1:0];
         s_w      = s_arr[win_idx];
         r_w      = r_arr[win_idx];
         err_next = |(s_w & r_w);
         for (int b = 0; b < WIDTH; b++) begin
            case ({s_w[b], r_w[b]})
               CMD_SET: q_next[b] = 1'b1;
               CMD_CLR: q_next[b] = 1'b0;
               default: q_next[b] = q_reg[b];   // CMD_HOLD and CMD_BAD
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         gnt_reg   <= '0;
         q_reg     <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         gnt_reg   <= gnt_next;
         q_reg     <= q_next;
         err_reg   <= err_next;
      end
   end

`ifdef SR_ARB_LOCK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_reg <= '0;
      end else begin
         owner_reg <= owner_next;
      end
   end
`endif

   assign gnt  = gnt_reg;
   assign q    = q_reg;
   assign err  = err_reg;
   assign busy = (state_reg != IDLE);

endmodule
